// File: rtl/prog_loader.sv
// prog_loader: streams machine-code words into instruction RAM while holding
// the core in reset. It then releases the core and counts run cycles until
// core_done, and reports the cycle count or an overflow/timeout error.
module prog_loader #(
  parameter int D       = 10,
  parameter int W       = 9,
  parameter int RST_CYC = 2,
  parameter int MAXCYC  = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         start,
  output logic         core_reset,
  input  logic         core_done,
  output logic         ram_we,
  output logic [D-1:0] ram_addr,
  output logic [W-1:0] ram_wdata,
  output logic [D:0]   prog_len,
  output logic [15:0]  cycles,
  output logic         busy,
  output logic         fin,
  output logic [1:0]   err
);

  localparam int         RW   = $clog2(RST_CYC + 1);
  localparam logic [D:0] CAP  = {1'b1, {D{1'b0}}};
  localparam logic [15:0] MAXC = 16'(MAXCYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [D-1:0]    addr_q;
  logic [RW-1:0]   rst_cnt_q;
  logic [15:0]     cnt_q;

  logic            counting;
  logic            wr;
  logic            ovf;
  logic            run_done;
  logic            run_tmo;
  logic            go;
  logic            enter_run;

  // The core only runs once the post-entry reset hold has expired.
  assign counting   = (state_q == S_RUN) && (rst_cnt_q == '0);
  assign core_reset = ~counting;
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign fin        = (state_q == S_DONE);
  assign enter_run  = (state_d == S_RUN) && (state_q != S_RUN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    wr       = 1'b0;
    ovf      = 1'b0;
    run_done = 1'b0;
    run_tmo  = 1'b0;
    go       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (in_valid) begin
          // A full RAM rejects the word rather than wrapping the address.
          if (prog_len == CAP) begin
            ovf     = 1'b1;
            state_d = S_ERR;
          end else begin
            wr = 1'b1;
            if (in_last) state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Done is checked before the limit so a simultaneous finish is not an error.
        if (counting) begin
          if (core_done) begin
            run_done = 1'b1;
            state_d  = S_DONE;
          end else if (cnt_q == MAXC) begin
            run_tmo = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start && (prog_len != '0)) begin
          go      = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port, load bookkeeping, run counters and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      addr_q    <= '0;
      prog_len  <= '0;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      cycles    <= '0;
      err       <= 2'b00;
    end else begin
      ram_we <= wr;
      if (state_q == S_IDLE) begin
        addr_q   <= '0;
        prog_len <= '0;
      end
      if (wr) begin
        ram_addr  <= addr_q;
        ram_wdata <= in_data;
        addr_q    <= addr_q + 1'b1;
        prog_len  <= prog_len + 1'b1;
      end
      if (ovf) err <= 2'b01;
      if (enter_run) begin
        rst_cnt_q <= RW'(RST_CYC);
        cnt_q     <= '0;
        cycles    <= '0;
        err       <= 2'b00;
      end else if (state_q == S_RUN) begin
        if (rst_cnt_q != '0) begin
          rst_cnt_q <= rst_cnt_q - 1'b1;
        end else if (run_done) begin
          cycles <= cnt_q;
        end else if (run_tmo) begin
          cycles <= MAXC;
          err    <= 2'b10;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Front-end stage upstream of the processor top level.
- Accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them into the instruction memory.
- Holds the core in reset during loading, then releases it and counts execution cycles until the core raises done.
- Reports the result: run cycle count, or overflow/timeout status.

Parameters:
D, 10, instruction address width; capacity = 2**D words
W, 9, machine-code word width
RST_CYC, 2, cycles core_reset stays high after entering RUN (minimum 1)
MAXCYC, 65535, run-cycle limit before timeout; must fit in 16 bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  loader can accept a word
in_data  input  W  machine-code word
in_last  input  1  marks final word of the program
start  input  1  re-run the loaded program (honoured in DONE/ERR if len>0)
core_reset  output  1  active-high reset to the processor top level
core_done  input  1  processor done flag
ram_we  output  1  instruction RAM write strobe
ram_addr  output  D  instruction RAM write address
ram_wdata  output  W  instruction RAM write data
prog_len  output  D+1  number of words loaded
cycles  output  16  cycles counted with core_reset low, latched at completion
busy  output  1  high in LOAD or RUN
fin  output  1  high in DONE
err  output  2  00 none, 01 overflow, 10 timeout

Behaviour:
- Asynchronous reset (reset=0) forces state IDLE and clears all registers.
- Output values under reset: in_ready=0, core_reset=1, ram_we=0, ram_addr=0, ram_wdata=0, prog_len=0, cycles=0, busy=0, fin=0, err=00.
- States: IDLE, LOAD, RUN, DONE, ERR. Transitions occur on the rising edge.
- IDLE: one cycle only, then LOAD. in_ready=0. Clears the write address and prog_len.
- LOAD:
  - in_ready=1 and core_reset=1.
  - A transfer occurs when in_valid and in_ready are both high.
  - On a transfer, the next cycle shows ram_we=1, ram_addr=current address, ram_wdata=in_data. The write is registered, so latency is 1 cycle. The address then increments and prog_len increments.
  - If a transfer has in_last=1, the state goes to RUN after that write.
  - If a transfer arrives while prog_len==2**D, the word is not written, err=01, and the state goes to ERR. The final legal address is 2**D-1; ram_addr never wraps.
  - in_valid with in_ready low (any non-LOAD state) is ignored, and no data is consumed.
- RUN:
  - core_reset stays 1 for RST_CYC cycles, then drops to 0.
  - The cycle counter starts at 0 and increments each cycle that core_reset=0.
  - core_done is sampled only while core_reset=0. core_done=1 latches the current count into cycles, sets core_reset=1 (freezing the core), and moves to DONE.
  - If the counter reaches MAXCYC without core_done: cycles=MAXCYC, err=10, core_reset=1, state goes to ERR.
  - If core_done and the limit occur in the same cycle, done wins and err stays 00.
- DONE: fin=1, core_reset=1. If start=1 and prog_len>0, go to RUN with the program left intact; err and cycles are cleared on entry to RUN.
- ERR: core_reset=1, err held. start behaves as in DONE. An overflowed load still allows start with the 2**D words already loaded.
- A new program load requires reset. start is ignored in IDLE, LOAD and RUN.
- ram_we is high for exactly one cycle per accepted word; it is never asserted outside LOAD or the cycle following the last transfer.
- Reset asserted mid-LOAD or mid-RUN aborts immediately: core_reset=1 and prog_len=0. The RAM contents are not cleared.

Test Plan:
- Load 3 words 0x1A5, 0x003, 0x0FF (last on the third) with in_valid held high -> ram_we pulses at addresses 0,1,2 with those data; prog_len=3; state RUN the cycle after the third write.
- Same load with in_valid toggling 1,0,1,0,1 -> identical RAM writes; no write on idle cycles; in_ready stays 1.
- RUN with core_done raised on the 5th cycle after core_reset falls (RST_CYC=2) -> cycles=4; fin=1; core_reset=1; err=00.
- Parameterise MAXCYC=20 and never raise done -> err=10, cycles=20, core_reset=1. Then pulse start and raise done after 7 counted cycles -> err=00, cycles=7, fin=1.
- Parameterise D=2 and stream 5 words without in_last -> 4 writes (addresses 0-3), 5th rejected, err=01, prog_len=4, no address wrap.
- Assert reset during RUN at cycle 3 -> core_reset=1 asynchronously; all outputs at reset values; next load restarts at address 0.
